// File: rtl/qformat_mac.sv
// qformat_mac
//   Pipelined signed fixed-point multiply-accumulate engine.
//   Operands are Q(INT_BITS).(FRAC_BITS), W = 1+INT_BITS+FRAC_BITS bits.
//   Products are kept at full precision and summed in an ACC_W-bit
//   accumulator. A pair flagged in_last emits one rounded, saturated
//   result and clears the accumulator.
//
//   Optional feature macro: QFORMAT_MAC_OVF_STICKY_EN
//     defined   : ovf_sticky latches any saturated result until ovf_clr
//     undefined : ovf_sticky tied low, ovf_clr ignored
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   in_valid   in   1  operand pair valid
//   in_ready   out  1  pair can be accepted this cycle
//   in_a       in   W  signed operand A
//   in_b       in   W  signed operand B
//   in_last    in   1  final pair of the current sum
//   out_valid  out  1  result valid
//   out_ready  in   1  downstream accepts result
//   out_data   out  W  rounded, saturated sum
//   out_sat    out  1  out_data was clamped
//   ovf_sticky out  1  sticky saturation flag
//   ovf_clr    in   1  clears ovf_sticky

module qformat_mac #(
    parameter int INT_BITS   = 7,
    parameter int FRAC_BITS  = 8,
    parameter int GUARD_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INT_BITS+FRAC_BITS:0]   in_a,
    input  logic [INT_BITS+FRAC_BITS:0]   in_b,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INT_BITS+FRAC_BITS:0]   out_data,
    output logic                          out_sat,
    output logic                          ovf_sticky,
    input  logic                          ovf_clr
);

    localparam int W     = 1 + INT_BITS + FRAC_BITS;
    localparam int ACC_W = 2*W + GUARD_BITS;
    localparam int RND_W = ACC_W + 1;     // one extra bit so the rounding add cannot wrap

    localparam logic signed [RND_W-1:0] MAX_V = {{(RND_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RND_W-1:0] MIN_V = {{(RND_W-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [RND_W-1:0] HALF  = RND_W'(2**(FRAC_BITS-1));

    logic                    w_stall;
    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic signed [W-1:0]     r_s1_a;
    logic signed [W-1:0]     r_s1_b;
    logic                    r_s2_valid;
    logic                    r_s2_last;
    logic signed [2*W-1:0]   r_s2_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_out_valid;
    logic [W-1:0]            r_out_data;
    logic                    r_out_sat;

    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [RND_W-1:0] w_rnd;
    logic signed [RND_W-1:0] w_r;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic                    w_sat;
    logic [W-1:0]            w_out;
    logic                    w_emit;

    // Whole pipeline freezes while a result waits for the consumer.
    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            r_s1_last  <= in_last;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_prod  <= '0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_prod  <= r_s1_a * r_s1_b;
        end
    end

    always_comb begin
        w_prod_ext = {{GUARD_BITS{r_s2_prod[2*W-1]}}, r_s2_prod};
        w_sum      = r_acc + w_prod_ext;
        w_rnd      = {w_sum[ACC_W-1], w_sum} + HALF;
        w_r        = w_rnd >>> FRAC_BITS;
        w_sat_hi   = (w_r > MAX_V);
        w_sat_lo   = (w_r < MIN_V);
        w_sat      = w_sat_hi | w_sat_lo;
        if (w_sat_hi) begin
            w_out = {1'b0, {(W-1){1'b1}}};
        end else if (w_sat_lo) begin
            w_out = {1'b1, {(W-1){1'b0}}};
        end else begin
            w_out = w_r[W-1:0];
        end
        w_emit     = ~w_stall & r_s2_valid & r_s2_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (!w_stall) begin
            if (r_s2_valid) begin
                if (r_s2_last) begin
                    r_acc      <= '0;
                    r_out_data <= w_out;
                    r_out_sat  <= w_sat;
                end else begin
                    r_acc <= w_sum;
                end
            end
            // Not stalled means any pending result was just consumed.
            r_out_valid <= r_s2_valid & r_s2_last;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

`ifdef QFORMAT_MAC_OVF_STICKY_EN
    logic r_ovf_sticky;

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_emit && w_sat) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = ovf_clr | w_emit;
    assign ovf_sticky   = 1'b0;
`endif

endmodule
